data_mem_responder: RTL and testbench
=====================================

# data_mem_responder

Responder end of the core's data-memory port. It accepts one load or store request at a time from the datapath (`address`, `writeData`, funct3, write flag) through a req/ready handshake. It inserts a configurable number of wait states, then performs the access on an internal word-organised little-endian RAM. It returns sign- or zero-extended load data, or flags misaligned and illegal accesses. It replaces the combinational data memory so the core can be tested against a slow memory.

## Interface
- `DEPTH_WORDS`, 1024: RAM size in 32-bit words; power of two, at least 4.
- `WAIT`, 2: wait-state cycles inserted between accept and response, 0..15.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `req` in 1: request valid. Held high by the requester until it sees `ready`.
- `we` in 1: 1 = store, 0 = load.
- `f3` in 3: access size/sign (RV32I funct3).
- `address` in 16: byte address from the datapath ALU result.
- `writeData` in 32: store data (rs2).
- `readData` out 32: load result.
- `ready` out 1: one-cycle response strobe.
- `err` out 1: access fault, valid only while `ready`=1.
- `busy` out 1: high while a request is in flight.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: on a rising edge with `req`=1, latch `we`, `f3`, `address` and `writeData`, and load the wait counter with `WAIT`.
  - If `WAIT`=0, go to RESP.
  - Otherwise go to WAIT.
- WAIT: decrement the counter each cycle. Go to RESP on the edge where the counter reaches 1.
- RESP: `ready`=1 for exactly one cycle, then go to IDLE unconditionally.
- Request inputs are ignored outside IDLE. Only latched values are used.
- Word index is `address[log2(DEPTH_WORDS)+1:2]`. Upper address bits are discarded, so addresses wrap modulo `DEPTH_WORDS*4`.
- Byte lane is `address[1:0]`, little-endian: lane 0 = bits 7:0.
- Loads:
  - 000 lb: byte, sign-extended.
  - 001 lh: halfword at `address[1]`, sign-extended.
  - 010 lw: full word.
  - 100 lbu: byte, zero-extended.
  - 101 lhu: halfword, zero-extended.
- Stores:
  - 000 sb: `writeData[7:0]` into the addressed lane.
  - 001 sh: `writeData[15:0]` into the addressed halfword.
  - 010 sw: full word.
  - Other lanes of the word are preserved.
- Fault, signalled with `err`=1 and `ready`=1:
  - `f3` is 011, 110 or 111.
  - Any store with `f3[2]`=1.
  - Halfword access with `address[0]`=1.
  - Word access with `address[1:0]`≠0.
  - On a fault there is no RAM write and `readData`=0.
- `readData` is updated on the response edge of a non-faulting load, and is 0 on a fault. A successful store leaves it unchanged.
- RAM contents are not reset.

## Timing
- Reset (`rst_n`=0 at an edge): state IDLE, `ready`=0, `err`=0, `busy`=0, `readData`=0, counter=0.
- Reset overrides every other event in the same cycle.
- Latency: request accepted at edge N, so `ready`=1 during cycle N+1+`WAIT`. Back-to-back throughput is one access per `WAIT`+2 cycles.
- Store write commits at the same edge that raises `ready`.
- Reset asserted before that edge aborts the store: no write happens and no `ready` is issued.
- `busy`=1 from the cycle after accept through the RESP cycle inclusive.
- `err` is low whenever `ready` is low.
- The requester drops `req` on the edge that samples `ready`=1. If `req` is still high in the IDLE cycle following RESP, it is accepted as a new request.
- A load issued immediately after a store to the same word returns the new data.

## Test plan
- `WAIT`=2: sw `0xDEADBEEF` @ `0x0010`, then lw @ `0x0010`.
  - `ready` pulses 3 cycles after each accept.
  - `readData`=`0xDEADBEEF`, `err`=0.
- After the above:
  - lb @ `0x0013` gives `0xFFFFFFDE`.
  - lbu @ `0x0013` gives `0x000000DE`.
  - lh @ `0x0012` gives `0xFFFFDEAD`.
  - lhu @ `0x0010` gives `0x0000BEEF`.
- sb `0x12345678` @ `0x0011` over `0xDEADBEEF`, then lw @ `0x0010` gives `0xDEAD78EF`.
- Faults:
  - lw @ `0x0012`, sh @ `0x0011` and f3=011 each give `ready`=1, `err`=1, `readData`=0.
  - A following lw @ `0x0010` confirms no write occurred.
- `DEPTH_WORDS`=1024: sw `0xA5A5A5A5` @ `0x1004`, then lw @ `0x0004` gives `0xA5A5A5A5` (wrap).
- Start sw `0x11111111` @ `0x0020`, assert `rst_n`=0 one cycle after accept.
  - No `ready` is issued.
  - After release, lw @ `0x0020` returns the prior contents.
  - `WAIT`=0 run: `ready` arrives in the cycle after accept.

Source files
------------

// File: rtl/data_mem_responder.sv
// data_mem_responder: req/ready data-memory responder with wait states over a word-organised little-endian RAM.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        we,
  input  logic [2:0]  f3,
  input  logic [15:0] address,
  input  logic [31:0] writeData,
  output logic [31:0] readData,
  output logic        ready,
  output logic        err,
  output logic        busy
);
  localparam int AW = $clog2(DEPTH_WORDS);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
  state_t st;
  logic [3:0] cnt;
  logic we_q;
  logic [2:0] f3_q;
  logic [15:0] a_q;
  logic [31:0] wd_q;
  logic [31:0] mem [DEPTH_WORDS];
  logic idle, fire, c_we, fault;
  logic [2:0] c_f3;
  logic [15:0] c_a;
  logic [31:0] c_wd, word, ld, mask, rep;
  logic [7:0] b;
  logic [15:0] h;
  logic [AW-1:0] idx;
  logic unused_ok;
  assign unused_ok = &{1'b0, address, a_q};
  // With zero wait states the access happens on the accept edge, so it must see the live inputs.
  always_comb begin
    idle = st == S_IDLE;
    c_we = idle ? we : we_q;
    c_f3 = idle ? f3 : f3_q;
    c_a = idle ? address : a_q;
    c_wd = idle ? writeData : wd_q;
    idx = c_a[AW+1:2];
    word = mem[idx];
    b = word[{c_a[1:0], 3'b000} +: 8];
    h = word[{c_a[1], 4'b0000} +: 16];
    fault = (c_f3 == 3'b011) | (c_f3[2:1] == 2'b11) | (c_we & c_f3[2]) |
            ((c_f3[1:0] == 2'b01) & c_a[0]) | ((c_f3[1:0] == 2'b10) & (c_a[1:0] != 2'b00));
    ld = (c_f3[1:0] == 2'b00) ? {{24{~c_f3[2] & b[7]}}, b} :
         (c_f3[1:0] == 2'b01) ? {{16{~c_f3[2] & h[15]}}, h} : word;
    mask = (c_f3[1:0] == 2'b00) ? 32'h0000_00FF << {c_a[1:0], 3'b000} :
           (c_f3[1:0] == 2'b01) ? 32'h0000_FFFF << {c_a[1], 4'b0000} : 32'hFFFF_FFFF;
    rep = (c_f3[1:0] == 2'b00) ? {4{c_wd[7:0]}} :
          (c_f3[1:0] == 2'b01) ? {2{c_wd[15:0]}} : c_wd;
    fire = idle ? (req && (WAIT == 0)) : ((st == S_WAIT) && (cnt == 4'd1));
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st <= S_IDLE;
      cnt <= '0;
      ready <= 1'b0;
      err <= 1'b0;
      busy <= 1'b0;
      readData <= '0;
    end else begin
      ready <= fire;
      err <= fire & fault;
      if (fire && (fault || !c_we)) readData <= fault ? '0 : ld;
      case (st)
        S_IDLE: if (req) begin
          we_q <= we;
          f3_q <= f3;
          a_q <= address;
          wd_q <= writeData;
          cnt <= 4'(WAIT);
          busy <= 1'b1;
          st <= (WAIT == 0) ? S_RESP : S_WAIT;
        end
        S_WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) st <= S_RESP;
        end
        S_RESP: begin
          busy <= 1'b0;
          st <= S_IDLE;
        end
        default: st <= S_IDLE;
      endcase
    end
  end
  always_ff @(posedge clk)
    if (rst_n && fire && c_we && !fault) mem[idx] <= (word & ~mask) | (rep & mask);
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: model-checked bench for data_mem_responder (WAIT=2) plus a WAIT=0 instance.
module tb_data_mem_responder;
  localparam int DEPTH = 1024;
  localparam int WAIT = 2;
  logic clk = 0, rst_n = 0, req = 0, we = 0;
  logic [2:0] f3 = 0;
  logic [15:0] address = 0;
  logic [31:0] writeData = 0;
  logic [31:0] readData;
  logic ready, err, busy;
  logic req0 = 0, we0 = 0;
  logic [2:0] f30 = 0;
  logic [15:0] address0 = 0;
  logic [31:0] writeData0 = 0;
  logic [31:0] readData0;
  logic ready0, err0, busy0;
  int cyc = 0, compared = 0, mismatched = 0;
  int acc = -1, exp_cycle = -1, rdy_cyc = 0;
  logic exp_err = 0, chk_en = 0, resp_e;
  logic [31:0] rd_before = 0, rd_after = 0, resp_d;
  logic [31:0] m [int];

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT(WAIT)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .f3(f3), .address(address),
    .writeData(writeData), .readData(readData), .ready(ready), .err(err), .busy(busy));
  data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .req(req0), .we(we0), .f3(f30), .address(address0),
    .writeData(writeData0), .readData(readData0), .ready(ready0), .err(err0), .busy(busy0));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] expv);
    compared++;
    if (act !== expv) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, expv, cyc);
    end
  endfunction

  // Byte-level memory model: faults, lane writes and extended loads.
  task automatic model(input logic w, input logic [2:0] f, input logic [15:0] a,
                       input logic [31:0] d, output logic e, output logic [31:0] v);
    int size, lane, idx;
    logic [31:0] word;
    size = (f[1:0] == 2'b00) ? 1 : (f[1:0] == 2'b01) ? 2 : 4;
    lane = int'(a) % 4;
    idx = (int'(a) / 4) % DEPTH;
    e = (f == 3'b011) || (f >= 3'b110) || (w && f[2]) || (lane % size != 0);
    word = m.exists(idx) ? m[idx] : 32'h0;
    v = 32'h0;
    if (e) v = 32'h0;
    else if (w) begin
      for (int k = 0; k < size; k++)
        word = (word & ~(32'hFF << (8 * (lane + k)))) | (((d >> (8 * k)) & 32'hFF) << (8 * (lane + k)));
      m[idx] = word;
      v = rd_after;
    end else begin
      for (int k = 0; k < size; k++) v = v | (((word >> (8 * (lane + k))) & 32'hFF) << (8 * k));
      if (!f[2] && size < 4 && v[8 * size - 1]) v = v | ~((32'd1 << (8 * size)) - 32'd1);
    end
  endtask

  always @(negedge clk) if (chk_en) begin
    chk("ready", {31'b0, ready}, {31'b0, cyc == exp_cycle});
    chk("busy", {31'b0, busy}, {31'b0, cyc >= acc && cyc <= exp_cycle && acc >= 0});
    chk("err", {31'b0, err}, {31'b0, cyc == exp_cycle && exp_err});
    chk("readData", readData, (cyc >= exp_cycle) ? rd_after : rd_before);
  end

  task automatic xact(input logic w, input logic [2:0] f, input logic [15:0] a, input logic [31:0] d);
    logic e;
    logic [31:0] v;
    int n;
    @(negedge clk);
    req = 1; we = w; f3 = f; address = a; writeData = d;
    @(posedge clk); #1;
    model(w, f, a, d, e, v);
    acc = cyc; exp_cycle = cyc + WAIT; exp_err = e; rd_before = rd_after; rd_after = v;
    n = 0;
    do begin @(negedge clk); n++; end while (ready !== 1'b1 && n < 40);
    if (ready !== 1'b1) begin
      compared++; mismatched++;
      $display("FAIL ready_timeout: got no ready expected ready within 40 cycles");
    end
    rdy_cyc = cyc; resp_d = readData; resp_e = err; req = 0;
  endtask

  task automatic pin(string nm, logic [31:0] d, logic e);
    chk(nm, resp_d, d);
    chk({nm, "_err"}, {31'b0, resp_e}, {31'b0, e});
  endtask

  task automatic x0(string nm, input logic w, input logic [2:0] f, input logic [15:0] a,
                    input logic [31:0] d, input logic [31:0] ed, input logic ee);
    @(negedge clk);
    req0 = 1; we0 = w; f30 = f; address0 = a; writeData0 = d;
    @(posedge clk); #1;
    @(negedge clk);
    chk({nm, "_rdy"}, {31'b0, ready0}, 32'd1);
    chk({nm, "_err"}, {31'b0, err0}, {31'b0, ee});
    if (!w || ee) chk({nm, "_data"}, readData0, ed);
    req0 = 0;
    @(negedge clk);
    chk({nm, "_rdy_low"}, {31'b0, ready0}, 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'b0, ready}, 32'd0);
    chk("rst_err", {31'b0, err}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_readData", readData, 32'd0);
    rst_n = 1; chk_en = 1;
    xact(1, 3'b010, 16'h0010, 32'hDEADBEEF);
    chk("sw_latency", rdy_cyc - acc, 32'd2);
    xact(0, 3'b010, 16'h0010, 32'h0);
    chk("lw_latency", rdy_cyc - acc, 32'd2);
    pin("lw_10", 32'hDEADBEEF, 0);
    xact(0, 3'b000, 16'h0013, 32'h0); pin("lb_13", 32'hFFFFFFDE, 0);
    xact(0, 3'b100, 16'h0013, 32'h0); pin("lbu_13", 32'h000000DE, 0);
    xact(0, 3'b001, 16'h0012, 32'h0); pin("lh_12", 32'hFFFFDEAD, 0);
    xact(0, 3'b101, 16'h0010, 32'h0); pin("lhu_10", 32'h0000BEEF, 0);
    xact(1, 3'b000, 16'h0011, 32'h12345678);
    xact(0, 3'b010, 16'h0010, 32'h0); pin("lw_after_sb", 32'hDEAD78EF, 0);
    xact(0, 3'b010, 16'h0012, 32'h0); pin("lw_misalign", 32'h0, 1);
    xact(1, 3'b001, 16'h0011, 32'hFFFFFFFF); pin("sh_misalign", 32'h0, 1);
    xact(0, 3'b011, 16'h0010, 32'h0); pin("f3_011", 32'h0, 1);
    xact(1, 3'b100, 16'h0010, 32'h0); pin("store_f3hi", 32'h0, 1);
    xact(0, 3'b010, 16'h0010, 32'h0); pin("lw_nowrite", 32'hDEAD78EF, 0);
    xact(1, 3'b010, 16'h1004, 32'hA5A5A5A5);
    xact(0, 3'b010, 16'h0004, 32'h0); pin("lw_wrap", 32'hA5A5A5A5, 0);
    xact(1, 3'b001, 16'h0022, 32'h0000BEAD);
    xact(1, 3'b010, 16'h0020, 32'hCAFEF00D);
    @(negedge clk);
    req = 1; we = 1; f3 = 3'b010; address = 16'h0020; writeData = 32'h11111111;
    @(posedge clk); #1;
    acc = cyc; exp_cycle = cyc + WAIT; exp_err = 0; rd_before = rd_after;
    @(negedge clk);
    req = 0; rst_n = 0; chk_en = 0;
    repeat (4) begin
      chk("abort_ready", {31'b0, ready}, 32'd0);
      @(negedge clk);
    end
    acc = -1; exp_cycle = -1; rd_before = 0; rd_after = 0;
    rst_n = 1; chk_en = 1;
    xact(0, 3'b010, 16'h0020, 32'h0); pin("lw_after_abort", 32'hCAFEF00D, 0);
    chk_en = 0;
    x0("w0_sw", 1, 3'b010, 16'h0040, 32'h0BADF00D, 32'h0, 0);
    x0("w0_lw", 0, 3'b010, 16'h0040, 32'h0, 32'h0BADF00D, 0);
    x0("w0_lhu", 0, 3'b101, 16'h0042, 32'h0, 32'h00000BAD, 0);
    x0("w0_lh_mis", 0, 3'b001, 16'h0041, 32'h0, 32'h0, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $fatal(1, "FAIL global_timeout: got no finish expected finish before 200000");
  end
endmodule
